timer_counter: RTL and testbench

//  Memory-mapped programmable down-counter with interrupt output. One instance sits on each device

---
 rtl/timer_counter.sv | 115 +++++++++++
 tb/tb_timer_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with interrupt output.
// Three word registers (CTRL, PRESET, COUNT) behind a 2-bit word address; one-shot or auto-reload.
module timer_counter #(
  parameter logic [31:0] PRESET_INIT = 32'h0000_0000,
  parameter logic [3:0]  CTRL_INIT   = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0] preset_q, preset_d;
  logic [DW-1:0] count_q, count_d;
  logic          flag_q, flag_d;
  logic          irq_d;

  logic en, mode_reload, wr_ctrl, wr_preset;

  assign en          = ctrl_q[0];
  assign mode_reload = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl     = we && (addr == 2'd0);
  assign wr_preset   = we && (addr == 2'd1);

  // State and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ctrl_q   <= CTRL_INIT;
      preset_q <= PRESET_INIT;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq      <= irq_d;
    end
  end

  // Next state; FSM decisions use the pre-edge CTRL, then CPU writes override
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    if (wr_ctrl || wr_preset) flag_d = 1'b0;

    case (state_q)
      S_IDLE: if (en) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q != '0) begin
          count_d = DW'(count_q - DW'(1));
        end else begin
          state_d = S_INT;
          flag_d  = 1'b1;
        end
      end
      S_INT: begin
        if (mode_reload) begin
          state_d = S_LOAD;
          flag_d  = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_ctrl)   ctrl_d   = wd[CW-1:0];
    if (wr_preset) preset_d = wd;
  end

  // irq is registered from the next-cycle mask and flag so it tracks IM & irq_flag
  assign irq_d = ctrl_d[3] & flag_d;

  // Read mux
  always_comb begin
    rd = '0;
    case (addr)
      2'd0:    rd = {{(DW-CW){1'b0}}, ctrl_q};
      2'd1:    rd = preset_q;
      2'd2:    rd = count_q;
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: hand-computed register/irq values at each cycle of interest.
module tb_timer_counter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_counter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .we   (we),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  // Write lands on the next rising edge; returns 1ns after that edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wd    = '0;
    #1;
    chk_irq("reset_irq", 1'b0);
    chk_rd("reset_ctrl", 2'd0, 32'h0);
    chk_rd("reset_preset", 2'd1, 32'h0);
    chk_rd("reset_count", 2'd2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0 one-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(2);
    chk_rd("m0_t2_count", 2'd2, 32'd5);
    chk_irq("m0_t2_irq", 1'b0);
    tick(5);
    chk_rd("m0_t7_count", 2'd2, 32'd0);
    chk_irq("m0_t7_irq", 1'b0);
    tick(1);
    chk_irq("m0_t8_irq", 1'b1);
    chk_rd("m0_t8_ctrl", 2'd0, 32'h9);
    tick(1);
    chk_rd("m0_t9_ctrl", 2'd0, 32'h8);
    chk_irq("m0_t9_irq", 1'b1);
    tick(3);
    chk_irq("m0_hold_irq", 1'b1);
    chk_rd("m0_hold_count", 2'd2, 32'd0);
    wr(2'd0, 32'h8);
    chk_irq("m0_clear_irq", 1'b0);

    // Mode 1 auto-reload, PRESET=3: 6-cycle period
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    tick(6);
    for (int p = 0; p < 4; p++) begin
      chk_irq("m1_pulse_hi", 1'b1);
      tick(1);
      chk_irq("m1_pulse_lo", 1'b0);
      tick(5);
    end
    chk_rd("m1_ctrl", 2'd0, 32'hB);
    chk_rd("m1_int_count", 2'd2, 32'd0);
    wr(2'd0, 32'h8);
    tick(2);
    chk_rd("m1_stop_count", 2'd2, 32'd3);
    chk_irq("m1_stop_irq", 1'b0);

    // Disable mid-count then re-enable
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    tick(2);
    chk_rd("dis_t2_count", 2'd2, 32'd10);
    tick(4);
    chk_rd("dis_t6_count", 2'd2, 32'd6);
    wr(2'd0, 32'h8);
    chk_rd("dis_t7_count", 2'd2, 32'd5);
    tick(4);
    chk_rd("dis_frozen_count", 2'd2, 32'd5);
    chk_irq("dis_irq", 1'b0);
    wr(2'd0, 32'h9);
    tick(1);
    chk_rd("reen_s1_count", 2'd2, 32'd5);
    tick(1);
    chk_rd("reen_s2_count", 2'd2, 32'd10);
    wr(2'd0, 32'h8);
    tick(1);
    chk_rd("reen_stop_count", 2'd2, 32'd9);

    // Masked irq, EN still auto-clears
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    tick(2);
    chk_rd("mask_t2_count", 2'd2, 32'd2);
    tick(3);
    chk_irq("mask_t5_irq", 1'b0);
    chk_rd("mask_t5_ctrl", 2'd0, 32'h1);
    tick(1);
    chk_rd("mask_t6_ctrl", 2'd0, 32'h0);
    chk_irq("mask_t6_irq", 1'b0);

    // PRESET write and COUNT write during a mode-1 run
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h3);
    tick(2);
    chk_rd("pw_t2_count", 2'd2, 32'd4);
    wr(2'd1, 32'd6);
    chk_rd("pw_t3_count", 2'd2, 32'd3);
    wr(2'd2, 32'hFFFF);
    chk_rd("cw_t4_count", 2'd2, 32'd2);
    chk_rd("pw_preset", 2'd1, 32'd6);
    tick(2);
    chk_rd("pw_t6_count", 2'd2, 32'd0);
    tick(3);
    chk_rd("pw_reload_count", 2'd2, 32'd6);
    wr(2'd0, 32'h0);
    tick(1);
    chk_rd("pw_stop_count", 2'd2, 32'd5);

    // Collision: CTRL write on the edge the flag sets
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick(2);
    chk_rd("col_t2_count", 2'd2, 32'd1);
    tick(1);
    chk_rd("col_t3_count", 2'd2, 32'd0);
    wr(2'd0, 32'h8);
    chk_irq("col_set_irq", 1'b1);
    chk_rd("col_set_ctrl", 2'd0, 32'h8);
    tick(1);
    chk_irq("col_t5_irq", 1'b1);
    chk_rd("col_t5_ctrl", 2'd0, 32'h8);

    // Collision: CTRL write on the edge INT clears EN
    wr(2'd0, 32'h9);
    tick(4);
    chk_irq("col2_t4_irq", 1'b1);
    wr(2'd0, 32'hD);
    chk_rd("col2_ctrl_kept", 2'd0, 32'hD);
    chk_irq("col2_irq_clr", 1'b0);
    tick(2);
    chk_rd("col2_t7_count", 2'd2, 32'd1);
    tick(2);
    chk_irq("col2_t9_irq", 1'b1);

    // Asynchronous reset with irq asserted
    #2;
    rst_n = 1'b0;
    #1;
    chk_irq("rst2_irq", 1'b0);
    chk_rd("rst2_ctrl", 2'd0, 32'h0);
    chk_rd("rst2_preset", 2'd1, 32'h0);
    chk_rd("rst2_addr3", 2'd3, 32'h0);
    chk_rd("rst2_count", 2'd2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
